// File: rtl/neuron_fetch_ctrl.sv
// Column sequencer for neuron_fetch_unit: one cache read per K-cycle column period, K activations out per column.
// Latency: read in cycle 1 after start, store +1, first output +2; done_o 1 cycle after the last output.
// Backpressure: none, free-running once started; NFC_BASE_ADDR_EN adds a latched base column address.
module neuron_fetch_ctrl #(
    parameter int ADDR_BIT_WIDTH         = 10,
    parameter int FILTER_WIDTH_BIT_WIDTH = 3,
    parameter int COUNT_BIT_WIDTH        = 8
) (
    input  logic                              clk,
    input  logic                              layer_reset_n,
    input  logic                              start_i,
    input  logic [FILTER_WIDTH_BIT_WIDTH-1:0] filter_width_i,
    input  logic [COUNT_BIT_WIDTH-1:0]        map_width_i,
    input  logic [COUNT_BIT_WIDTH-1:0]        out_rows_i,
`ifdef NFC_BASE_ADDR_EN
    input  logic [ADDR_BIT_WIDTH-1:0]         base_addr_i,
`endif
    output logic                              fetch_rd_en_o,
    output logic [ADDR_BIT_WIDTH-1:0]         fetch_addr_o,
    output logic                              store_data_en_o,
    output logic                              output_neuron_ac_en_o,
    output logic                              channel_switch_en_o,
    output logic                              addressing_en_o,
    output logic                              busy_o,
    output logic                              done_o
);

    localparam logic [FILTER_WIDTH_BIT_WIDTH-1:0] MAX_FW = FILTER_WIDTH_BIT_WIDTH'(5);
    localparam logic [FILTER_WIDTH_BIT_WIDTH-1:0] ONE_FW = FILTER_WIDTH_BIT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_SWITCH = 3'd2,
        S_ADDR   = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                              state_q;
    state_t                              state_d;
    logic [FILTER_WIDTH_BIT_WIDTH-1:0]   k_q;
    logic [FILTER_WIDTH_BIT_WIDTH-1:0]   k_start;
    logic [FILTER_WIDTH_BIT_WIDTH-1:0]   k_last;
    logic [FILTER_WIDTH_BIT_WIDTH-1:0]   phase_q;
    logic [COUNT_BIT_WIDTH-1:0]          map_width_q;
    logic [COUNT_BIT_WIDTH-1:0]          out_rows_q;
    logic [COUNT_BIT_WIDTH-1:0]          row_q;
    logic [COUNT_BIT_WIDTH-1:0]          col_q;
    logic                                store_q;
    logic [FILTER_WIDTH_BIT_WIDTH-1:0]   out_cnt_q;
    logic [ADDR_BIT_WIDTH-1:0]           col_addr;
    logic                                period_end;
    logic                                last_col;
    logic                                last_row;
    logic                                drain_ok;

    // Filter widths beyond 5 saturate, so K never exceeds 6.
    assign k_start    = ((filter_width_i > MAX_FW) ? MAX_FW : filter_width_i) + ONE_FW;
    assign k_last     = k_q - ONE_FW;
    assign period_end = (phase_q == k_last);
    assign last_col   = (col_q == map_width_q);
    assign last_row   = (row_q == out_rows_q);
    // Exit DRAIN in the cycle of the final output pulse so done_o lands right after it.
    assign drain_ok   = !store_q && (out_cnt_q <= ONE_FW);

`ifdef NFC_BASE_ADDR_EN
    logic [ADDR_BIT_WIDTH-1:0] base_q;

    always_ff @(posedge clk or negedge layer_reset_n) begin
        if (!layer_reset_n) begin
            base_q <= '0;
        end else if (state_q == S_IDLE && start_i) begin
            base_q <= base_addr_i;
        end
    end

    assign col_addr = base_q + ADDR_BIT_WIDTH'(col_q);
`else
    assign col_addr = ADDR_BIT_WIDTH'(col_q);
`endif

    always_ff @(posedge clk or negedge layer_reset_n) begin
        if (!layer_reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (period_end && last_col) begin
                    state_d = last_row ? S_DRAIN : S_SWITCH;
                end
            end
            S_SWITCH: state_d = S_ADDR;
            S_ADDR:   state_d = S_READ;
            S_DRAIN: begin
                if (drain_ok) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fetch_rd_en_o       = 1'b0;
        fetch_addr_o        = '0;
        channel_switch_en_o = 1'b0;
        addressing_en_o     = 1'b0;
        busy_o              = (state_q != S_IDLE);
        done_o              = 1'b0;
        case (state_q)
            S_READ: begin
                if (phase_q == '0) begin
                    fetch_rd_en_o = 1'b1;
                    fetch_addr_o  = col_addr;
                end
            end
            S_SWITCH: channel_switch_en_o = 1'b1;
            S_ADDR:   addressing_en_o     = 1'b1;
            S_DONE:   done_o              = 1'b1;
            default: ;
        endcase
    end

    // Configuration latch plus row/column/phase walk.
    always_ff @(posedge clk or negedge layer_reset_n) begin
        if (!layer_reset_n) begin
            k_q         <= '0;
            map_width_q <= '0;
            out_rows_q  <= '0;
            row_q       <= '0;
            col_q       <= '0;
            phase_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        k_q         <= k_start;
                        map_width_q <= map_width_i;
                        out_rows_q  <= out_rows_i;
                        row_q       <= '0;
                        col_q       <= '0;
                        phase_q     <= '0;
                    end
                end
                S_READ: begin
                    if (period_end) begin
                        phase_q <= '0;
                        col_q   <= col_q + 1'b1;
                    end else begin
                        phase_q <= phase_q + ONE_FW;
                    end
                end
                S_ADDR: begin
                    row_q   <= row_q + 1'b1;
                    col_q   <= '0;
                    phase_q <= '0;
                end
                default: ;
            endcase
        end
    end

    // Output pipeline: the cache answers one cycle after the read, then K activations stream out.
    always_ff @(posedge clk or negedge layer_reset_n) begin
        if (!layer_reset_n) begin
            store_q   <= 1'b0;
            out_cnt_q <= '0;
        end else begin
            store_q <= fetch_rd_en_o;
            if (store_q) begin
                out_cnt_q <= k_q;
            end else if (out_cnt_q != '0) begin
                out_cnt_q <= out_cnt_q - ONE_FW;
            end
        end
    end

    assign store_data_en_o       = store_q;
    assign output_neuron_ac_en_o = (out_cnt_q != '0);

endmodule

// File: tb/tb_neuron_fetch_ctrl.sv
// Directed bench for neuron_fetch_ctrl: per-cycle expected output vectors queued at start, popped each cycle.
module tb_neuron_fetch_ctrl;

    typedef struct packed {
        logic       rd;
        logic [9:0] addr;
        logic       st;
        logic       ac;
        logic       sw;
        logic       ad;
        logic       busy;
        logic       done;
    } obs_t;

    logic       clk;
    logic       layer_reset_n;
    logic       start_i;
    logic [2:0] filter_width_i;
    logic [7:0] map_width_i;
    logic [7:0] out_rows_i;
    logic [9:0] base_addr_i;
    logic       fetch_rd_en_o;
    logic [9:0] fetch_addr_o;
    logic       store_data_en_o;
    logic       output_neuron_ac_en_o;
    logic       channel_switch_en_o;
    logic       addressing_en_o;
    logic       busy_o;
    logic       done_o;

    int   n_cmp  = 0;
    int   n_fail = 0;
    obs_t exp_q[$];

    neuron_fetch_ctrl dut (
        .clk                   (clk),
        .layer_reset_n         (layer_reset_n),
        .start_i               (start_i),
        .filter_width_i        (filter_width_i),
        .map_width_i           (map_width_i),
        .out_rows_i            (out_rows_i),
`ifdef NFC_BASE_ADDR_EN
        .base_addr_i           (base_addr_i),
`endif
        .fetch_rd_en_o         (fetch_rd_en_o),
        .fetch_addr_o          (fetch_addr_o),
        .store_data_en_o       (store_data_en_o),
        .output_neuron_ac_en_o (output_neuron_ac_en_o),
        .channel_switch_en_o   (channel_switch_en_o),
        .addressing_en_o       (addressing_en_o),
        .busy_o                (busy_o),
        .done_o                (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Address is only meaningful while a read is expected.
    function automatic obs_t sample(input logic rd_expected);
        obs_t o;
        o.rd   = fetch_rd_en_o;
        o.addr = rd_expected ? fetch_addr_o : 10'd0;
        o.st   = store_data_en_o;
        o.ac   = output_neuron_ac_en_o;
        o.sw   = channel_switch_en_o;
        o.ad   = addressing_en_o;
        o.busy = busy_o;
        o.done = done_o;
        return o;
    endfunction

    task automatic check(input string tag, input int cyc, input obs_t e);
        obs_t o;
        o = sample(e.rd);
        n_cmp++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s cyc %0d: observed %b expected %b", tag, cyc, o, e);
        end
    endtask

    // Expected trace derived from the timing rules: row period M*K + 2, outputs K cycles after each store.
    task automatic build(input int fw, input int mw, input int rows, input int base);
        obs_t arr[0:511];
        int k, m, r_n, p, rs, rdc, last_out, done_c;
        k   = ((fw > 5) ? 5 : fw) + 1;
        m   = mw + 1;
        r_n = rows + 1;
        p   = m * k + 2;
        for (int i = 0; i < 512; i++) arr[i] = '0;
        last_out = 0;
        for (int r = 0; r < r_n; r++) begin
            rs = 1 + r * p;
            for (int c = 0; c < m; c++) begin
                rdc = rs + c * k;
                arr[rdc].rd   = 1'b1;
                arr[rdc].addr = 10'((base + c) % 1024);
                arr[rdc+1].st = 1'b1;
                for (int j = 1; j <= k; j++) arr[rdc+1+j].ac = 1'b1;
                last_out = rdc + 1 + k;
            end
            if (r < r_n - 1) begin
                arr[rs+m*k].sw   = 1'b1;
                arr[rs+m*k+1].ad = 1'b1;
            end
        end
        done_c = last_out + 1;
        arr[done_c].done = 1'b1;
        for (int i = 1; i <= done_c; i++) arr[i].busy = 1'b1;
        for (int i = 1; i <= done_c + 1; i++) exp_q.push_back(arr[i]);
    endtask

    // Entered at a negedge; start is sampled at the next posedge (edge 0).
    task automatic run_pass(input string tag, input int fw, input int mw, input int rows,
                            input int base, input int busy_cyc, input int abort_cyc);
        obs_t e;
        build(fw, mw, rows, base);
        filter_width_i = 3'(fw);
        map_width_i    = 8'(mw);
        out_rows_i     = 8'(rows);
        base_addr_i    = 10'(base);
        start_i        = 1'b1;
        @(posedge clk);
        for (int t = 1; exp_q.size() > 0; t++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check(tag, t, e);
            start_i = 1'b0;
            if (t == busy_cyc) start_i = 1'b1;
            if (e.done && abort_cyc == 0) start_i = 1'b1;
            if (t == abort_cyc) begin
                layer_reset_n = 1'b0;
                #1;
                check({tag, "_async_rst"}, t, '0);
                for (int j = 1; j <= 20; j++) begin
                    @(negedge clk);
                    check({tag, "_in_rst"}, t + j, '0);
                end
                layer_reset_n = 1'b1;
                @(negedge clk);
                check({tag, "_after_rst"}, t + 21, '0);
                exp_q.delete();
            end
        end
        start_i = 1'b0;
    endtask

    initial begin
        layer_reset_n  = 1'b0;
        start_i        = 1'b0;
        filter_width_i = 3'd0;
        map_width_i    = 8'd0;
        out_rows_i     = 8'd0;
        base_addr_i    = 10'd0;
        repeat (2) @(negedge clk);
        check("reset_state", 0, '0);
        start_i = 1'b1;
        @(negedge clk);
        check("start_in_reset", 0, '0);
        start_i       = 1'b0;
        layer_reset_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 0, '0);

        run_pass("single_col",   2, 3, 0, 0, 0, 0);
        run_pass("row_switch",   2, 3, 1, 0, 0, 0);
        run_pass("k1",           0, 4, 0, 0, 0, 0);
        run_pass("k1_rows",      0, 2, 2, 0, 0, 0);
        run_pass("fw5",          5, 1, 0, 0, 0, 0);
        run_pass("fw7_clamp",    7, 1, 0, 0, 0, 0);
        run_pass("fw6_rows",     6, 2, 1, 0, 0, 0);
        run_pass("k2_wide",      1, 9, 2, 0, 0, 0);
        run_pass("reset_mid",    2, 3, 0, 0, 0, 6);
        run_pass("restart",      2, 3, 0, 0, 0, 0);
        run_pass("start_busy",   2, 3, 0, 0, 5, 0);
        run_pass("single_only",  4, 0, 0, 0, 0, 0);
`ifdef NFC_BASE_ADDR_EN
        run_pass("base_wrap",    2, 3, 0, 1022, 0, 0);
        run_pass("base_rows",    0, 2, 1, 1023, 0, 0);
`endif
        repeat (2) @(negedge clk);
        check("final_idle", 0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
